// File: rtl/rx_fifo_drain_ctrl_if.sv
// FIFO read port and host valid/ready handshake of the RX drain controller.
interface rx_fifo_drain_ctrl_if;
    logic       n_re_o;
    logic [7:0] data_i;
    logic       p_empty_i;
    logic [7:0] data_o;
    logic       p_valid_o;
    logic       p_ready_i;

    modport master (
        output n_re_o, data_o, p_valid_o,
        input  data_i, p_empty_i, p_ready_i
    );

    modport slave (
        input  n_re_o, data_o, p_valid_o,
        output data_i, p_empty_i, p_ready_i
    );
endinterface

// File: rtl/rx_fifo_drain_ctrl.sv
// Drains RX FIFO bytes one at a time to a valid/ready host port, with
// threshold/idle-timeout interrupt causes and a saturating parity error count.
module rx_fifo_drain_ctrl #(
    parameter int TIMEOUT_W = 16,
    parameter int THRESH_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_fifo_drain_ctrl_if.master bus,
    input  logic                 n_we_i,
    input  logic                 p_ParityError_i,
    input  logic                 p_Enable_i,
    input  logic [THRESH_W-1:0]  Threshold_i,
    input  logic [TIMEOUT_W-1:0] Timeout_i,
    input  logic                 p_IrqClr_i,
    output logic [1:0]           IrqCause_o,
    output logic                 p_Irq_o,
    output logic [7:0]           ParityErrCnt_o
);

    localparam int S_IDLE = 0;
    localparam int S_READ = 1;
    localparam int S_LOAD = 2;
    localparam int S_HOLD = 3;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_READ = 4'b0010;
    localparam logic [3:0] ST_LOAD = 4'b0100;
    localparam logic [3:0] ST_HOLD = 4'b1000;

    logic [3:0]           state_q, state_d;
    logic [7:0]           data_q;
    logic [THRESH_W-1:0]  deliv_q, deliv_d, deliv_inc;
    logic [TIMEOUT_W-1:0] idle_q, idle_d, idle_inc;
    logic [1:0]           cause_q, cause_d;
    logic                 par_q;
    logic [7:0]           perr_q, perr_d;

    logic n_re, p_valid, load;
    logic xfer, thr_hit, to_hit;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable only gates the start of a new byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (p_Enable_i && !bus.p_empty_i) state_d = ST_READ;
            ST_READ: state_d = ST_LOAD;
            ST_LOAD: state_d = ST_HOLD;
            ST_HOLD: if (bus.p_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from the one-hot state flops, so they are glitch-free
    always_comb begin
        n_re    = 1'b1;
        p_valid = 1'b0;
        load    = 1'b0;
        if (state_q[S_READ]) n_re    = 1'b0;
        if (state_q[S_LOAD]) load    = 1'b1;
        if (state_q[S_HOLD]) p_valid = 1'b1;
    end

    assign bus.n_re_o    = n_re;
    assign bus.p_valid_o = p_valid;
    assign bus.data_o    = data_q;

    assign xfer      = p_valid & bus.p_ready_i;
    assign deliv_inc = deliv_q + 1'b1;
    assign idle_inc  = (&idle_q) ? idle_q : idle_q + 1'b1;

    // Timeout fires on the edge the idle count reaches the limit, so the cause
    // lands exactly Timeout_i cycles after the last delivery or write.
    always_comb begin
        deliv_d = deliv_q;
        idle_d  = idle_q;
        thr_hit = 1'b0;
        to_hit  = 1'b0;
        if (xfer) begin
            if (Threshold_i != '0 && deliv_inc == Threshold_i) begin
                thr_hit = 1'b1;
                deliv_d = '0;
            end else begin
                deliv_d = deliv_inc;
            end
        end
        if (!n_we_i || xfer || deliv_q == '0) begin
            idle_d = '0;
        end else if (Timeout_i != '0 && idle_inc == Timeout_i) begin
            to_hit  = 1'b1;
            idle_d  = '0;
            deliv_d = '0;
        end else begin
            idle_d = idle_inc;
        end
    end

    // A set in the same cycle as a clear wins
    assign cause_d = (cause_q & ~{2{p_IrqClr_i}}) | {to_hit, thr_hit};

    always_comb begin
        perr_d = perr_q;
        if (p_ParityError_i && !par_q && perr_q != 8'hFF) perr_d = perr_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= 8'h00;
            deliv_q <= '0;
            idle_q  <= '0;
            cause_q <= 2'b00;
            par_q   <= 1'b0;
            perr_q  <= 8'h00;
        end else begin
            if (load) data_q <= bus.data_i;
            deliv_q <= deliv_d;
            idle_q  <= idle_d;
            cause_q <= cause_d;
            par_q   <= p_ParityError_i;
            perr_q  <= perr_d;
        end
    end

    assign IrqCause_o     = cause_q;
    assign p_Irq_o        = |cause_q;
    assign ParityErrCnt_o = perr_q;

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// Directed bench for rx_fifo_drain_ctrl with a small behavioural RX FIFO.
module tb_rx_fifo_drain_ctrl;

    logic        clk;
    logic        rst;
    logic        n_we;
    logic        par;
    logic        en;
    logic [3:0]  thr;
    logic [15:0] to;
    logic        clr;
    logic [1:0]  cause;
    logic        irq;
    logic [7:0]  perr;

    rx_fifo_drain_ctrl_if bus ();

    rx_fifo_drain_ctrl #(.TIMEOUT_W(16), .THRESH_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .n_we_i         (n_we),
        .p_ParityError_i(par),
        .p_Enable_i     (en),
        .Threshold_i    (thr),
        .Timeout_i      (to),
        .p_IrqClr_i     (clr),
        .IrqCause_o     (cause),
        .p_Irq_o        (irq),
        .ParityErrCnt_o (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after n_re_o is sampled low
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int re_cnt = 0;
    int xfer_cnt = 0;
    logic [7:0] rdata = 8'h00;

    assign bus.p_empty_i = (wr_ptr == rd_ptr);
    assign bus.data_i    = rdata;

    always @(posedge clk) begin
        if (!bus.n_re_o) begin
            rdata  <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
            re_cnt <= re_cnt + 1;
        end
        if (bus.p_valid_o && bus.p_ready_i) xfer_cnt <= xfer_cnt + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_xfer(input int target);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (xfer_cnt >= target) break;
        end
        chk("wait_xfer", xfer_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; n_we = 1'b1; par = 1'b0; en = 1'b0;
        thr = '0; to = '0; clr = 1'b0; bus.p_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_n_re",  bus.n_re_o, 1);
        chk("rst_valid", bus.p_valid_o, 0);
        chk("rst_data",  bus.data_o, 8'h00);
        chk("rst_cause", cause, 0);
        chk("rst_irq",   irq, 0);
        chk("rst_perr",  perr, 0);

        // single byte, latency
        rst = 1'b1; en = 1'b1; bus.p_ready_i = 1'b1;
        push(8'hA5);
        @(negedge clk);
        chk("lat_read_nre", bus.n_re_o, 0);
        chk("lat_read_vld", bus.p_valid_o, 0);
        @(negedge clk);
        chk("lat_load_nre", bus.n_re_o, 1);
        chk("lat_load_vld", bus.p_valid_o, 0);
        @(negedge clk);
        chk("lat_hold_vld", bus.p_valid_o, 1);
        chk("lat_hold_data", bus.data_o, 8'hA5);
        @(negedge clk);
        chk("lat_idle_vld", bus.p_valid_o, 0);
        chk("lat_re_cnt", re_cnt, 1);
        chk("lat_xfer_cnt", xfer_cnt, 1);

        // backpressure in HOLD
        bus.p_ready_i = 1'b0;
        push(8'h3C);
        push(8'h77);
        repeat (3) @(negedge clk);
        chk("bp_vld", bus.p_valid_o, 1);
        chk("bp_data", bus.data_o, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", bus.p_valid_o, 1);
            chk("bp_hold_data", bus.data_o, 8'h3C);
            chk("bp_hold_re", re_cnt, 2);
        end
        bus.p_ready_i = 1'b1;
        wait_xfer(3);
        chk("bp_data2", bus.data_o, 8'h77);
        chk("bp_re_cnt", re_cnt, 3);

        // threshold
        do_reset();
        thr = 4'd3;
        push(8'h01); push(8'h02);
        wait_xfer(5);
        chk("thr_before", cause, 2'b00);
        push(8'h03);
        wait_xfer(6);
        chk("thr_hit", cause, 2'b01);
        chk("thr_irq", irq, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("thr_clr", cause, 2'b00);
        push(8'h04); push(8'h05);
        wait_xfer(8);
        chk("thr_mid", cause, 2'b00);
        bus.p_ready_i = 1'b0;
        push(8'h06);
        repeat (3) @(negedge clk);
        chk("thr6_hold", bus.p_valid_o, 1);
        bus.p_ready_i = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("thr_set_wins", cause, 2'b01);
        chk("thr6_xfer", xfer_cnt, 9);

        // idle timeout
        do_reset();
        thr = '0;
        to = 16'd20;
        push(8'h11);
        wait_xfer(10);
        repeat (19) @(negedge clk);
        chk("to_early", cause, 2'b00);
        @(negedge clk);
        chk("to_hit", cause, 2'b10);
        chk("to_irq", irq, 1);
        to = '0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("to_clr", cause, 2'b00);
        push(8'h12);
        wait_xfer(11);
        repeat (40) @(negedge clk);
        chk("to_disabled", cause, 2'b00);

        // parity edge counting and saturation
        do_reset();
        par = 1'b1;
        repeat (5) @(negedge clk);
        par = 1'b0;
        @(negedge clk);
        chk("perr_level", perr, 8'd1);
        for (int i = 0; i < 253; i++) begin
            par = 1'b1;
            @(negedge clk);
            par = 1'b0;
            @(negedge clk);
        end
        chk("perr_fe", perr, 8'hFE);
        for (int i = 0; i < 47; i++) begin
            par = 1'b1;
            @(negedge clk);
            par = 1'b0;
            @(negedge clk);
        end
        chk("perr_sat", perr, 8'hFF);

        // reset while holding a byte
        thr = 4'd1;
        push(8'h22);
        wait_xfer(12);
        chk("pre_rst_cause", cause, 2'b01);
        thr = '0;
        bus.p_ready_i = 1'b0;
        push(8'h33);
        repeat (3) @(negedge clk);
        chk("pre_rst_vld", bus.p_valid_o, 1);
        chk("pre_rst_data", bus.data_o, 8'h33);
        rst = 1'b0;
        @(negedge clk);
        chk("hrst_vld", bus.p_valid_o, 0);
        chk("hrst_nre", bus.n_re_o, 1);
        chk("hrst_data", bus.data_o, 8'h00);
        chk("hrst_cause", cause, 2'b00);
        chk("hrst_irq", irq, 0);
        chk("hrst_perr", perr, 8'h00);
        rst = 1'b1;

        // enable dropped mid-byte
        bus.p_ready_i = 1'b1;
        push(8'h5A);
        @(negedge clk);
        chk("en_read", bus.n_re_o, 0);
        en = 1'b0;
        push(8'h66);
        @(negedge clk);
        @(negedge clk);
        chk("en_hold_vld", bus.p_valid_o, 1);
        chk("en_hold_data", bus.data_o, 8'h5A);
        @(negedge clk);
        chk("en_done_vld", bus.p_valid_o, 0);
        chk("en_xfer", xfer_cnt, 13);
        repeat (5) @(negedge clk);
        chk("en_blocked_re", re_cnt, 14);
        chk("en_blocked_vld", bus.p_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
